ps2_rx_ctrl: RTL and testbench
==============================

// Module: ps2_rx_ctrl
// PURPOSE
//  PS/2 device-to-host receive controller. Synchronises and filters ps2_clk/ps2_data,
//  deframes 11-bit frames (start, 8 data LSB-first, odd parity, stop) and sequences
//  the downstream Nbit_register through its enable/d inputs.
//  Sits between the PS/2 pins and the keyboard/mouse data holding register.
// PARAMETERS
//  DATA_W       8     payload width; PS/2 requires 8, kept for register width match
//  FILT_LEN     4     consecutive equal samples needed to accept a ps2_clk/ps2_data level change
//  TIMEOUT_CYC  5000  clk cycles without a falling edge before an open frame is aborted
// PORTS
//  clk         in   1       system clock, all logic on rising edge
//  reset       in   1       asynchronous, active-low reset (0 = reset)
//  ps2_clk     in   1       raw PS/2 clock pin, asynchronous, idle high
//  ps2_data    in   1       raw PS/2 data pin, asynchronous, idle high
//  reg_enable  out  1       one-cycle load strobe to Nbit_register.enable
//  reg_d       out  DATA_W  received byte to Nbit_register.d; valid while reg_enable=1
//  rx_done     out  1       one-cycle pulse, same cycle as reg_enable
//  parity_err  out  1       one-cycle pulse: parity check failed, frame dropped
//  frame_err   out  1       one-cycle pulse: stop bit 0 or timeout, frame dropped
//  busy        out  1       1 while FSM is not IDLE
// BEHAVIOUR
//  - Reset (reset=0): FSM=IDLE; bit_cnt=0; shift reg=0; all outputs 0; sync and filter
//    flops preset to 1 (idle-high) so reset release never makes a false falling edge.
//  - Input path: 2-flop sync per line, then filter: filtered level changes only after
//    FILT_LEN equal synced samples. fall_tick = filtered ps2_clk 1->0, one clk wide.
//    Pin edge to fall_tick latency: 2+FILT_LEN clk cycles.
//  - All bits sampled from filtered ps2_data in the cycle of fall_tick.
//  - FSM (state changes only on fall_tick, except LOAD and timeout):
//    IDLE   : data=0 -> DATA, bit_cnt=0; data=1 -> stay IDLE (no error).
//    DATA   : shift data in at MSB, right shift (LSB-first), bit_cnt++; bit_cnt=DATA_W-1 -> PARITY.
//    PARITY : store parity bit; perr = ~^{shift,parity} (odd parity required) -> STOP.
//    STOP   : data=0 -> frame_err pulse, IDLE; data=1 & perr -> parity_err pulse, IDLE;
//             data=1 & !perr -> LOAD.
//    LOAD   : one cycle: reg_enable=1, rx_done=1, reg_d=shift -> IDLE unconditionally.
//  - Latency: reg_enable asserts exactly 1 clk after the fall_tick sampling the stop bit.
//  - reg_d holds the last loaded byte between loads (it is 0 after reset).
//  - Stop bit 0 with bad parity: only frame_err pulses.
//  - reset asserted mid-frame: immediate abort, no pulse, reset values as above.
//  - A fall_tick in the LOAD cycle cannot occur (filter spacing >= FILT_LEN); no handling needed.
// CONFIGURATION
//  PS2_RX_TIMEOUT_EN defined: idle counter cleared on every fall_tick and in IDLE;
//    when it reaches TIMEOUT_CYC-1 in a non-IDLE state, FSM -> IDLE and frame_err
//    pulses for one cycle; the partial byte is discarded.
//  Not defined: no counter is built; the FSM waits indefinitely; TIMEOUT_CYC unused.
// STRUCTURE
//  ps2_pkg: state enum (IDLE, DATA, PARITY, STOP, LOAD), PS2_FRAME_BITS=11,
//    PS2_IDLE_LEVEL=1'b1.
//  Sub-module ps2_in_filter (2-flop sync + FILT_LEN filter, one line), instantiated
//    for ps2_clk and ps2_data; FSM, shift reg and counters are in ps2_rx_ctrl.
// TESTING  (FILT_LEN=4, ps2_clk half-period >= 20 clk, data changes mid-high phase)
//  1 Frame 0xAB (start0, 1,1,0,1,0,1,0,1, parity0, stop1) -> one reg_enable+rx_done
//    pulse, reg_d=8'hAB, q=8'hAB next cycle, no error pulses.
//  2 Frame 0xFF with parity bit 0 (1 required) -> parity_err one pulse, no reg_enable,
//    reg_d keeps previous value.
//  3 Frame 0x55 parity1, stop bit 0 -> frame_err one pulse, no reg_enable, busy falls.
//  4 2-clk low glitch on ps2_clk while idle, then frame 0xAA parity1 -> glitch ignored,
//    busy stays 0 during glitch; reg_d=8'hAA.
//  5 reset=0 after 4 data bits, release, frame 0x11 parity1 -> no pulses during abort;
//    next frame gives reg_d=8'h11.
//  6 PS2_RX_TIMEOUT_EN, TIMEOUT_CYC=100: clocking stops after 3 data bits ->
//    frame_err exactly 100 clk after last fall_tick, busy=0; undefined macro ->
//    busy stays 1.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 receive path.
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        DATA   = 3'd1,
        PARITY = 3'd2,
        STOP   = 3'd3,
        LOAD   = 3'd4
    } ps2_state_e;

    localparam int unsigned PS2_FRAME_BITS = 11;
    localparam logic        PS2_IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/ps2_in_filter.sv
// Two-flop synchroniser plus glitch filter for one PS/2 line; the filtered level
// moves only after FILT_LEN consecutive synced samples disagree with it.
module ps2_in_filter
    import ps2_pkg::*;
#(
    parameter int unsigned FILT_LEN = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic pin,
    output logic level
);

    localparam int unsigned CNT_W = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;

    logic             sync_q1;
    logic             sync_q2;
    logic [CNT_W-1:0] cnt;

    // Presets follow the idle-high bus so reset release is not seen as an edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q1 <= PS2_IDLE_LEVEL;
            sync_q2 <= PS2_IDLE_LEVEL;
            level   <= PS2_IDLE_LEVEL;
            cnt     <= '0;
        end else begin
            sync_q1 <= pin;
            sync_q2 <= sync_q1;
            if (sync_q2 == level) begin
                cnt <= '0;
            end else if (cnt == CNT_W'(FILT_LEN - 1)) begin
                level <= sync_q2;
                cnt   <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/ps2_rx_ctrl.sv
// PS/2 device-to-host receiver: deframes 11-bit frames and strobes the holding register.
// Optional frame timeout enabled by defining PS2_RX_TIMEOUT_EN.
module ps2_rx_ctrl
    import ps2_pkg::*;
#(
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned FILT_LEN    = 4,
    parameter int unsigned TIMEOUT_CYC = 5000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ps2_clk,
    input  logic              ps2_data,
    output logic              reg_enable,
    output logic [DATA_W-1:0] reg_d,
    output logic              rx_done,
    output logic              parity_err,
    output logic              frame_err,
    output logic              busy
);

    localparam int unsigned BIT_CNT_W = $clog2(PS2_FRAME_BITS);

    logic clk_f;
    logic data_f;
    logic clk_prev;
    logic fall_tick;
    logic timeout_hit;

    ps2_state_e            state, state_nx;
    logic [DATA_W-1:0]     shift, shift_nx;
    logic [BIT_CNT_W-1:0]  bit_cnt, bit_cnt_nx;
    logic                  perr, perr_nx;
    logic                  load_nx;
    logic                  perr_pulse_nx;
    logic                  ferr_pulse_nx;

    ps2_in_filter #(.FILT_LEN(FILT_LEN)) u_clk_filt (
        .clk   (clk),
        .reset (reset),
        .pin   (ps2_clk),
        .level (clk_f)
    );

    ps2_in_filter #(.FILT_LEN(FILT_LEN)) u_data_filt (
        .clk   (clk),
        .reset (reset),
        .pin   (ps2_data),
        .level (data_f)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) clk_prev <= PS2_IDLE_LEVEL;
        else        clk_prev <= clk_f;
    end

    assign fall_tick = clk_prev & ~clk_f;

`ifdef PS2_RX_TIMEOUT_EN
    localparam int unsigned TO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    logic [TO_W-1:0] idle_cnt, idle_cnt_nx;

    // Counts cycles since the last falling edge; held at zero while idle.
    always_comb begin
        idle_cnt_nx = idle_cnt + TO_W'(1);
        if (fall_tick || (state == IDLE)) idle_cnt_nx = '0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) idle_cnt <= '0;
        else        idle_cnt <= idle_cnt_nx;
    end

    assign timeout_hit = (state != IDLE) && (idle_cnt_nx == TO_W'(TIMEOUT_CYC - 1));
`else
    logic [31:0] unused_timeout;

    assign unused_timeout = 32'(TIMEOUT_CYC);
    assign timeout_hit    = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            shift      <= '0;
            bit_cnt    <= '0;
            perr       <= 1'b0;
            reg_enable <= 1'b0;
            rx_done    <= 1'b0;
            reg_d      <= '0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state      <= state_nx;
            shift      <= shift_nx;
            bit_cnt    <= bit_cnt_nx;
            perr       <= perr_nx;
            reg_enable <= load_nx;
            rx_done    <= load_nx;
            parity_err <= perr_pulse_nx;
            frame_err  <= ferr_pulse_nx;
            busy       <= (state_nx != IDLE);
            if (load_nx) reg_d <= shift_nx;
        end
    end

    // Frame sequencing; every bit is taken from the filtered data line on fall_tick.
    always_comb begin
        state_nx      = state;
        shift_nx      = shift;
        bit_cnt_nx    = bit_cnt;
        perr_nx       = perr;
        load_nx       = 1'b0;
        perr_pulse_nx = 1'b0;
        ferr_pulse_nx = 1'b0;

        case (state)
            IDLE: begin
                if (fall_tick && !data_f) begin
                    state_nx   = DATA;
                    bit_cnt_nx = '0;
                end
            end
            DATA: begin
                if (fall_tick) begin
                    shift_nx   = {data_f, shift[DATA_W-1:1]};
                    bit_cnt_nx = bit_cnt + BIT_CNT_W'(1);
                    if (bit_cnt == BIT_CNT_W'(DATA_W - 1)) state_nx = PARITY;
                end
            end
            PARITY: begin
                if (fall_tick) begin
                    perr_nx  = ~^{shift, data_f};
                    state_nx = STOP;
                end
            end
            STOP: begin
                if (fall_tick) begin
                    if (!data_f) begin
                        ferr_pulse_nx = 1'b1;
                        state_nx      = IDLE;
                    end else if (perr) begin
                        perr_pulse_nx = 1'b1;
                        state_nx      = IDLE;
                    end else begin
                        load_nx  = 1'b1;
                        state_nx = LOAD;
                    end
                end
            end
            LOAD: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase

        // A stalled frame is dropped; only reachable when the timeout is built.
        if (timeout_hit) begin
            state_nx      = IDLE;
            load_nx       = 1'b0;
            perr_pulse_nx = 1'b0;
            ferr_pulse_nx = 1'b1;
        end
    end

endmodule

// File: tb/tb_ps2_rx_ctrl.sv
// Self-checking bench for ps2_rx_ctrl: directed frames plus randomized frames
// compared against an outcome model built from the PS/2 framing rules.
module tb_ps2_rx_ctrl;

    localparam int HP       = 20;
    localparam int FILT     = 4;
    localparam int TO_CYC   = 100;

    logic       clk;
    logic       reset;
    logic       ps2_clk;
    logic       ps2_data;
    logic       reg_enable;
    logic [7:0] reg_d;
    logic       rx_done;
    logic       parity_err;
    logic       frame_err;
    logic       busy;

    int n_checks   = 0;
    int n_errors   = 0;
    int n_load     = 0;
    int n_perr     = 0;
    int n_ferr     = 0;
    int n_done_mis = 0;

    logic [7:0] model_d;

    ps2_rx_ctrl #(
        .DATA_W      (8),
        .FILT_LEN    (FILT),
        .TIMEOUT_CYC (TO_CYC)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .reg_enable (reg_enable),
        .reg_d      (reg_d),
        .rx_done    (rx_done),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse accounting, sampled mid-cycle.
    always @(negedge clk) begin
        if (reset) begin
            if (reg_enable) n_load++;
            if (parity_err) n_perr++;
            if (frame_err)  n_ferr++;
            if (rx_done !== reg_enable) n_done_mis++;
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One PS/2 bit: data set mid-high, full low phase, then back to mid-high.
    task automatic ps2_bit(input logic b);
        ps2_data = b;
        step(HP / 2);
        ps2_clk = 1'b0;
        step(HP);
        ps2_clk = 1'b1;
        step(HP / 2);
    endtask

    task automatic send_frame(input string tag, input logic [7:0] b, input logic par,
                              input logic stop);
        int         ones;
        logic [3:0] exp_v;
        int         l0, p0, f0;
        l0 = n_load; p0 = n_perr; f0 = n_ferr;
        ones = $countones({b, par});
        if (!stop)          exp_v = 4'b0001;
        else if (ones % 2 == 0) exp_v = 4'b0010;
        else                exp_v = 4'b1100;

        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(b[i]);
        ps2_bit(par);

        ps2_data = stop;
        step(HP / 2);
        ps2_clk = 1'b0;
        step(FILT + 2);
        @(negedge clk);
        check({tag, "_pre_stop"}, {busy, reg_enable, parity_err, frame_err}, 4'b1000);
        @(negedge clk);
        check({tag, "_at_stop"}, {busy, reg_enable, parity_err, frame_err}, exp_v);
        step(HP - FILT - 3);
        ps2_clk = 1'b1;
        step(HP / 2);

        if (exp_v == 4'b1100) model_d = b;
        check({tag, "_reg_d"}, reg_d, model_d);
        check({tag, "_cnt"}, {n_load - l0, n_perr - p0, n_ferr - f0},
              {32'(exp_v[2]), 32'(exp_v[1]), 32'(exp_v[0])});
        check({tag, "_busy_end"}, busy, 1'b0);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        step(3);
        check("rst_outputs", {busy, reg_enable, rx_done, parity_err, frame_err}, 5'b0);
        check("rst_reg_d", reg_d, 8'h00);
        model_d = 8'h00;
        reset = 1'b1;
        step(10);
    endtask

    initial begin
        int         l0, p0, f0;
        logic       busy_seen;
        logic [7:0] rb;
        logic       rpar, rstop;

        reset    = 1'b0;
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        model_d  = 8'h00;
        step(5);
        check("reset_state", {busy, reg_enable, rx_done, parity_err, frame_err}, 5'b0);
        check("reset_reg_d", reg_d, 8'h00);
        reset = 1'b1;
        step(20);
        check("release_idle", {busy, n_load, n_perr, n_ferr}, 0);

        send_frame("ab_ok", 8'hAB, 1'b0, 1'b1);
        send_frame("ff_perr", 8'hFF, 1'b0, 1'b1);
        send_frame("55_ferr", 8'h55, 1'b1, 1'b0);
        send_frame("perr_ferr", 8'h0F, 1'b0, 1'b0);

        // Short low glitch on the clock line must be filtered away.
        busy_seen = 1'b0;
        ps2_clk = 1'b0;
        step(2);
        ps2_clk = 1'b1;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            busy_seen |= busy;
        end
        step(1);
        check("glitch_busy", busy_seen, 1'b0);
        send_frame("aa_after_glitch", 8'hAA, 1'b1, 1'b1);

        // Reset mid-frame aborts silently.
        l0 = n_load; p0 = n_perr; f0 = n_ferr;
        ps2_bit(1'b0);
        for (int i = 0; i < 4; i++) ps2_bit(1'b1);
        check("mid_busy", busy, 1'b1);
        do_reset();
        check("abort_pulses", {n_load - l0, n_perr - p0, n_ferr - f0}, 0);
        send_frame("11_after_abort", 8'h11, 1'b1, 1'b1);

        // Clocking stalls after three data bits.
        f0 = n_ferr;
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        ps2_bit(1'b0);
        ps2_data = 1'b1;
        step(HP / 2);
        ps2_clk = 1'b0;
        step(HP);
        ps2_clk = 1'b1;
        step(TO_CYC + FILT + 1 - HP);
        @(negedge clk);
        check("to_before", {busy, frame_err}, 2'b10);
        @(negedge clk);
`ifdef PS2_RX_TIMEOUT_EN
        check("to_at", {busy, frame_err}, 2'b01);
`else
        check("to_at", {busy, frame_err}, 2'b10);
`endif
        step(200);
`ifdef PS2_RX_TIMEOUT_EN
        check("to_after", {busy, 8'(n_ferr - f0)}, {1'b0, 8'd1});
`else
        check("to_after", {busy, 8'(n_ferr - f0)}, {1'b1, 8'd0});
`endif
        do_reset();

        for (int k = 0; k < 20; k++) begin
            rb    = 8'($urandom);
            rpar  = ($urandom_range(0, 9) < 7) ? ~^rb : ^rb;
            rstop = ($urandom_range(0, 9) < 8);
            send_frame($sformatf("rand%0d", k), rb, rpar, rstop);
        end

        check("rx_done_eq_enable", n_done_mis, 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
